redraw_sequencer: RTL

- Sits directly upstream of the VGA adapter and wraps the shape drawer's start/done handshake.
- On enable it clears the 160x120 frame to a background colour, snapshots the shape parameters, and launches the drawer.
- While the drawer runs, it forwards the drawer's pixel stream to the adapter, then watches the switch-derived parameters and triggers a clear-and-redraw whenever they change.

---
 rtl/redraw_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/redraw_sequencer.sv
// Clear-then-draw sequencer between the shape drawer and the VGA adapter; redraws when the
// requested shape changes. Define CLIP_EN to suppress off-screen drawer pixels during DRAW.
module redraw_sequencer #(
   parameter int         SCR_W     = 160,
   parameter int         SCR_H     = 120,
   parameter logic [2:0] BG_COLOUR = 3'b000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [2:0] req_colour,
   input  logic [7:0] req_centre_x,
   input  logic [6:0] req_centre_y,
   input  logic [7:0] req_diameter,
   output logic       drw_start,
   output logic [2:0] drw_colour,
   output logic [7:0] drw_centre_x,
   output logic [6:0] drw_centre_y,
   output logic [7:0] drw_diameter,
   input  logic       drw_done,
   input  logic [7:0] drw_x,
   input  logic [6:0] drw_y,
   input  logic [2:0] drw_colour_px,
   input  logic       drw_plot,
   output logic [7:0] vga_x,
   output logic [6:0] vga_y,
   output logic [2:0] vga_colour,
   output logic       vga_plot,
   output logic       busy,
   output logic [7:0] frame_count
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_CLEAR  = 3'd1;
   localparam logic [2:0] S_LAUNCH = 3'd2;
   localparam logic [2:0] S_DRAW   = 3'd3;
   localparam logic [2:0] S_HOLD   = 3'd4;

   localparam logic [7:0] X_LAST = 8'(SCR_W - 1);
   localparam logic [6:0] Y_LAST = 7'(SCR_H - 1);

   logic [2:0] state;
   logic [7:0] clr_x;
   logic [6:0] clr_y;
   logic       req_changed;
   logic       on_screen;

   // Full-width compare of the live request against the snapshot taken at LAUNCH
   assign req_changed = {req_colour, req_centre_x, req_centre_y, req_diameter} !=
                        {drw_colour, drw_centre_x, drw_centre_y, drw_diameter};

`ifdef CLIP_EN
   assign on_screen = ({1'b0, drw_x} < 9'(SCR_W)) && ({1'b0, drw_y} < 8'(SCR_H));
`else
   assign on_screen = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         clr_x        <= '0;
         clr_y        <= '0;
         drw_colour   <= '0;
         drw_centre_x <= '0;
         drw_centre_y <= '0;
         drw_diameter <= '0;
         frame_count  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (enable) begin
                  state <= S_CLEAR;
                  clr_x <= '0;
                  clr_y <= '0;
               end
            end
            S_CLEAR: begin
               if (clr_x == X_LAST) begin
                  clr_x <= '0;
                  if (clr_y == Y_LAST) begin
                     clr_y <= '0;
                     state <= S_LAUNCH;
                  end else begin
                     clr_y <= clr_y + 7'd1;
                  end
               end else begin
                  clr_x <= clr_x + 8'd1;
               end
            end
            S_LAUNCH: begin
               drw_colour   <= req_colour;
               drw_centre_x <= req_centre_x;
               drw_centre_y <= req_centre_y;
               drw_diameter <= req_diameter;
               state        <= S_DRAW;
            end
            S_DRAW: begin
               if (drw_done) begin
                  frame_count <= frame_count + 8'd1;
                  state       <= S_HOLD;
               end
            end
            S_HOLD: begin
               // A lingering done from the finished pass must drop before any decision
               if (!drw_done) begin
                  if (!enable) begin
                     state <= S_IDLE;
                  end else if (req_changed) begin
                     state <= S_CLEAR;
                     clr_x <= '0;
                     clr_y <= '0;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      busy       = (state != S_IDLE);
      drw_start  = (state == S_DRAW);
      vga_x      = '0;
      vga_y      = '0;
      vga_colour = '0;
      vga_plot   = 1'b0;
      case (state)
         S_CLEAR: begin
            vga_x      = clr_x;
            vga_y      = clr_y;
            vga_colour = BG_COLOUR;
            vga_plot   = 1'b1;
         end
         S_DRAW: begin
            vga_x      = drw_x;
            vga_y      = drw_y;
            vga_colour = drw_colour_px;
            vga_plot   = drw_plot & on_screen;
         end
         default: ;
      endcase
   end

endmodule
